// File: rtl/rk05_seq_pkg.sv
// Shared state encoding and default timing constants for the RK05 sector sequencer.
package rk05_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SECTOR,
    PREAMBLE,
    DATA,
    POSTAMBLE,
    DONE
  } seq_state_t;

  localparam logic [15:0] DEF_PREAMBLE_USEC  = 16'd120;
  localparam logic [15:0] DEF_DATA_USEC      = 16'd2600;
  localparam logic [15:0] DEF_POSTAMBLE_USEC = 16'd40;
  localparam logic [2:0]  DEF_MAX_REVS       = 3'd3;

endpackage

// File: rtl/usec_interval_counter.sv
// Microsecond interval counter: clears on demand, counts enables, flags the enable that reaches the limit.
module usec_interval_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        terminal
);

  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign terminal = enable && ((count + 16'd1) == limit);

endmodule

// File: rtl/sector_sequencer.sv
// RK05 sector read/write gate sequencer. Define RK05_SEQ_TIMEOUT_EN to enable the
// revolution-count timeout while waiting for the target sector.
module sector_sequencer
  import rk05_seq_pkg::*;
#(
  parameter logic [15:0] PREAMBLE_USEC  = DEF_PREAMBLE_USEC,
  parameter logic [15:0] DATA_USEC      = DEF_DATA_USEC,
  parameter logic [15:0] POSTAMBLE_USEC = DEF_POSTAMBLE_USEC,
  parameter logic [2:0]  MAX_REVS       = DEF_MAX_REVS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clkenbl_1usec,
  input  logic       clkenbl_sector,
  input  logic       clkenbl_index,
  input  logic [4:0] sector_address,
  input  logic [4:0] number_of_sectors,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [4:0] cmd_sector,
  output logic       read_gate,
  output logic       write_gate,
  output logic       data_window,
  output logic       busy,
  output logic       done_pulse,
  output logic       err_range,
  output logic       err_overrun,
  output logic       err_timeout
);

  seq_state_t  state, state_next;
  logic        sector_start;
  logic        latched_write;
  logic [4:0]  latched_sector;
  logic        accept;
  logic        range_bad;
  logic        overrun_hit;
  logic        rev_limit_hit;
  logic        timed_state;
  logic        gate_on;
  logic        usec_clear;
  logic        usec_terminal;
  logic [15:0] usec_limit;

  assign accept      = cmd_valid && cmd_ready;
  assign range_bad   = cmd_sector >= number_of_sectors;
  assign timed_state = (state == PREAMBLE) || (state == DATA) || (state == POSTAMBLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      sector_start   <= 1'b0;
      latched_write  <= 1'b0;
      latched_sector <= '0;
      err_range      <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      state        <= state_next;
      sector_start <= clkenbl_sector;
      if (accept) begin
        latched_write  <= cmd_write;
        latched_sector <= cmd_sector;
        err_range      <= range_bad;
        err_overrun    <= 1'b0;
      end else if (overrun_hit) begin
        err_overrun <= 1'b1;
      end
    end
  end

`ifdef RK05_SEQ_TIMEOUT_EN
  logic [2:0] rev_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      rev_count   <= '0;
      err_timeout <= 1'b0;
    end else if (accept) begin
      rev_count   <= '0;
      err_timeout <= 1'b0;
    end else if (state == WAIT_SECTOR) begin
      if (clkenbl_index) rev_count <= rev_count + 3'd1;
      if (state_next == DONE) err_timeout <= 1'b1;
    end
  end

  assign rev_limit_hit = clkenbl_index && ((rev_count + 3'd1) == MAX_REVS);
`else
  assign rev_limit_hit = 1'b0;
  assign err_timeout   = 1'b0;
`endif

  // A sector boundary inside the gated window is an overrun and wins over any interval exit.
  always_comb begin
    state_next  = state;
    usec_limit  = '0;
    overrun_hit = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = range_bad ? DONE : WAIT_SECTOR;
      end
      WAIT_SECTOR: begin
        if (sector_start && (sector_address == latched_sector)) state_next = PREAMBLE;
        else if (rev_limit_hit)                                 state_next = DONE;
      end
      PREAMBLE: begin
        usec_limit = PREAMBLE_USEC;
        if (sector_start) begin
          overrun_hit = 1'b1;
          state_next  = DONE;
        end else if (usec_terminal) begin
          state_next = DATA;
        end
      end
      DATA: begin
        usec_limit = DATA_USEC;
        if (sector_start) begin
          overrun_hit = 1'b1;
          state_next  = DONE;
        end else if (usec_terminal) begin
          state_next = POSTAMBLE;
        end
      end
      POSTAMBLE: begin
        usec_limit = POSTAMBLE_USEC;
        if (sector_start) begin
          overrun_hit = 1'b1;
          state_next  = DONE;
        end else if (usec_terminal) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign usec_clear = (state_next != state) || !timed_state;

  usec_interval_counter u_usec_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (usec_clear),
    .enable   (clkenbl_1usec),
    .limit    (usec_limit),
    .terminal (usec_terminal)
  );

  assign gate_on     = timed_state;
  assign write_gate  = gate_on && latched_write;
  assign read_gate   = gate_on && !latched_write;
  assign data_window = (state == DATA);
  assign busy        = (state != IDLE);
  assign done_pulse  = (state == DONE);
  assign cmd_ready   = (state == IDLE);

endmodule
